// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the D-register layout used by the fetch stage.
// Also holds the per-opcode function-code legality check.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_reg_t;

    localparam d_reg_t D_BUBBLE = '{
        stat:  STAT_AOK,
        icode: ICODE_NOP,
        ifun:  4'h0,
        ra:    REG_NONE,
        rb:    REG_NONE,
        valc:  64'd0,
        valp:  64'd0
    };

    // rrmovq/cmovXX and jXX take condition codes 0..6, OPq takes 0..3.
    function automatic logic instr_is_valid(input logic [3:0] icode, input logic [3:0] ifun);
        logic ok;
        case (icode)
            ICODE_RRMOVQ, ICODE_JXX: ok = (ifun <= 4'd6);
            ICODE_OPQ:               ok = (ifun <= 4'd3);
            ICODE_HALT, ICODE_NOP, ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ,
            ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ:
                                     ok = (ifun == 4'd0);
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/y86_fetch_align.sv
// Combinational split of the ten fetched bytes into Y86 instruction fields,
// plus the sequential successor PC.
module y86_fetch_align
    import y86_pkg::*;
(
    input  logic [79:0] imem_data,
    input  logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [63:0] valc,
    output logic [63:0] valp,
    output logic        need_regids,
    output logic        need_valc,
    output logic        instr_valid
);

    logic [7:0] byte0_s;
    logic [7:0] byte1_s;

    assign byte0_s = imem_data[7:0];
    assign byte1_s = imem_data[15:8];
    assign icode   = byte0_s[7:4];
    assign ifun    = byte0_s[3:0];

    // Decode which optional fields follow the opcode byte.
    always_comb begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (icode)
            ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ: need_regids = 1'b1;
            ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            ICODE_JXX, ICODE_CALL: need_valc = 1'b1;
            default: begin
                need_regids = 1'b0;
                need_valc   = 1'b0;
            end
        endcase
    end

    // Extract register ids and the little-endian constant; its offset depends on the regid byte.
    always_comb begin
        ra   = REG_NONE;
        rb   = REG_NONE;
        valc = 64'd0;
        if (need_regids) begin
            ra = byte1_s[7:4];
            rb = byte1_s[3:0];
        end else begin
            ra = REG_NONE;
            rb = REG_NONE;
        end
        if (!need_valc) begin
            valc = 64'd0;
        end else if (need_regids) begin
            valc = imem_data[79:16];
        end else begin
            valc = imem_data[71:8];
        end
    end

    assign valp        = pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
    assign instr_valid = instr_is_valid(icode, ifun);

endmodule

// File: rtl/y86_fetch_stage.sv
// Y86-64 pipeline fetch stage: PC selection, instruction decode via the align
// block, next-PC prediction and the F/D pipeline registers.
module y86_fetch_stage
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_data,
    input  logic        imem_err,
    output logic [1:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
);

    logic [63:0] pred_pc_r;
    d_reg_t      d_r;
    logic [63:0] pc_sel_s;
    logic [63:0] pred_next_s;
    d_reg_t      fetched_s;

    logic [3:0]  a_icode_s;
    logic [3:0]  a_ifun_s;
    logic [3:0]  a_ra_s;
    logic [3:0]  a_rb_s;
    logic [63:0] a_valc_s;
    logic [63:0] a_valp_s;
    logic        a_need_regids_s;
    logic        a_need_valc_s;
    logic        a_valid_s;

    // Mispredicted branch recovery takes priority over a returning ret.
    always_comb begin
        pc_sel_s = pred_pc_r;
        if (M_icode == ICODE_JXX && !M_Cnd) begin
            pc_sel_s = M_valA;
        end else if (W_icode == ICODE_RET) begin
            pc_sel_s = W_valM;
        end else begin
            pc_sel_s = pred_pc_r;
        end
    end

    assign imem_addr = pc_sel_s;

    y86_fetch_align u_align (
        .imem_data   (imem_data),
        .pc          (pc_sel_s),
        .icode       (a_icode_s),
        .ifun        (a_ifun_s),
        .ra          (a_ra_s),
        .rb          (a_rb_s),
        .valc        (a_valc_s),
        .valp        (a_valp_s),
        .need_regids (a_need_regids_s),
        .need_valc   (a_need_valc_s),
        .instr_valid (a_valid_s)
    );

    // Form the D-register candidate; a memory fault turns the slot into a nop at the faulting PC.
    always_comb begin
        fetched_s = D_BUBBLE;
        if (imem_err) begin
            fetched_s.stat  = STAT_ADR;
            fetched_s.icode = ICODE_NOP;
            fetched_s.ifun  = 4'h0;
            fetched_s.ra    = REG_NONE;
            fetched_s.rb    = REG_NONE;
            fetched_s.valc  = 64'd0;
            fetched_s.valp  = pc_sel_s;
        end else begin
            if (!a_valid_s) begin
                fetched_s.stat = STAT_INS;
            end else if (a_icode_s == ICODE_HALT) begin
                fetched_s.stat = STAT_HLT;
            end else begin
                fetched_s.stat = STAT_AOK;
            end
            fetched_s.icode = a_icode_s;
            fetched_s.ifun  = a_ifun_s;
            fetched_s.ra    = a_need_regids_s ? a_ra_s : REG_NONE;
            fetched_s.rb    = a_need_regids_s ? a_rb_s : REG_NONE;
            fetched_s.valc  = a_valc_s;
            fetched_s.valp  = a_valp_s;
        end
    end

    // Jumps and calls are predicted taken; everything else falls through.
    always_comb begin
        pred_next_s = fetched_s.valp;
        if (a_need_valc_s && (fetched_s.icode == ICODE_JXX || fetched_s.icode == ICODE_CALL)) begin
            pred_next_s = fetched_s.valc;
        end else begin
            pred_next_s = fetched_s.valp;
        end
    end

    // Predicted-PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_pc_r <= 64'd0;
        end else if (!F_stall) begin
            pred_pc_r <= pred_next_s;
        end else begin
            pred_pc_r <= pred_pc_r;
        end
    end

    // D pipeline register: stall outranks bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_r <= D_BUBBLE;
        end else if (D_stall) begin
            d_r <= d_r;
        end else if (D_bubble) begin
            d_r <= D_BUBBLE;
        end else begin
            d_r <= fetched_s;
        end
    end

    assign D_stat  = d_r.stat;
    assign D_icode = d_r.icode;
    assign D_ifun  = d_r.ifun;
    assign D_rA    = d_r.ra;
    assign D_rB    = d_r.rb;
    assign D_valC  = d_r.valc;
    assign D_valP  = d_r.valp;

endmodule

// File: tb/tb_y86_fetch_stage.sv
// Directed self-checking bench for y86_fetch_stage with hand-computed expectations.
module tb_y86_fetch_stage;

    logic        clk;
    logic        rst;
    logic        F_stall;
    logic        D_stall;
    logic        D_bubble;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_err;
    logic [1:0]  D_stat;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;

    int checks;
    int failures;

    localparam logic [79:0] I_IRMOVQ = 80'h0000_0000_0000_0010_F030;
    localparam logic [79:0] I_NOP    = 80'h0000_0000_0000_0000_0010;
    localparam logic [79:0] I_JMP20  = 80'h0000_0000_0000_0000_2070;
    localparam logic [79:0] I_JMP100 = 80'h0000_0000_0000_0001_0070;
    localparam logic [79:0] I_OPQ5   = 80'h0000_0000_0000_0000_0065;
    localparam logic [79:0] I_HALT   = 80'h0000_0000_0000_0000_0000;

    y86_fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .F_stall   (F_stall),
        .D_stall   (D_stall),
        .D_bubble  (D_bubble),
        .M_icode   (M_icode),
        .M_Cnd     (M_Cnd),
        .M_valA    (M_valA),
        .W_icode   (W_icode),
        .W_valM    (W_valM),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .imem_err  (imem_err),
        .D_stat    (D_stat),
        .D_icode   (D_icode),
        .D_ifun    (D_ifun),
        .D_rA      (D_rA),
        .D_rB      (D_rB),
        .D_valC    (D_valC),
        .D_valP    (D_valP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        D_bubble  = 1'b0;
        M_icode   = 4'h0;
        M_Cnd     = 1'b0;
        M_valA    = 64'd0;
        W_icode   = 4'h0;
        W_valM    = 64'd0;
        imem_data = I_IRMOVQ;
        imem_err  = 1'b0;
        #12;
        check_val("rst_stat", {62'd0, D_stat}, 64'd0);
        check_val("rst_icode", {60'd0, D_icode}, 64'd1);
        check_val("rst_ra", {60'd0, D_rA}, 64'hF);
        check_val("rst_addr", imem_addr, 64'd0);
        #2;
        rst = 1'b0;

        // irmovq $0x10, %rax at PC 0
        step();
        check_val("irm_icode", {60'd0, D_icode}, 64'd3);
        check_val("irm_ra", {60'd0, D_rA}, 64'hF);
        check_val("irm_rb", {60'd0, D_rB}, 64'h0);
        check_val("irm_valc", D_valC, 64'h10);
        check_val("irm_valp", D_valP, 64'd10);
        check_val("irm_stat", {62'd0, D_stat}, 64'd0);
        check_val("irm_addr", imem_addr, 64'd10);

        // F_stall alone: D still takes the nop, PC holds
        F_stall   = 1'b1;
        imem_data = I_NOP;
        step();
        check_val("fst_icode", {60'd0, D_icode}, 64'd1);
        check_val("fst_valp", D_valP, 64'd11);
        check_val("fst_addr", imem_addr, 64'd10);
        F_stall = 1'b0;

        // jmp 0x20 at PC 10
        imem_data = I_JMP20;
        step();
        check_val("j20_valp", D_valP, 64'h13);
        check_val("j20_addr", imem_addr, 64'h20);

        // jmp 0x100 at PC 0x20
        imem_data = I_JMP100;
        step();
        check_val("j100_valc", D_valC, 64'h100);
        check_val("j100_valp", D_valP, 64'h29);
        check_val("j100_addr", imem_addr, 64'h100);

        // Mispredict recovery and ret priority, combinational
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h29;
        #1;
        check_val("misp_addr", imem_addr, 64'h29);
        W_icode = 4'h9; W_valM = 64'h400; M_valA = 64'h50;
        #1;
        check_val("prio_m_addr", imem_addr, 64'h50);
        M_Cnd = 1'b1;
        #1;
        check_val("prio_w_addr", imem_addr, 64'h400);
        M_icode = 4'h0; M_Cnd = 1'b0; W_icode = 4'h0;
        #1;
        check_val("restore_addr", imem_addr, 64'h100);

        // Invalid OPq function at 0x100
        imem_data = I_OPQ5;
        step();
        check_val("ins_stat", {62'd0, D_stat}, 64'd3);
        check_val("ins_valp", D_valP, 64'h102);

        // halt at 0x102
        imem_data = I_HALT;
        step();
        check_val("hlt_stat", {62'd0, D_stat}, 64'd1);
        check_val("hlt_icode", {60'd0, D_icode}, 64'd0);
        check_val("hlt_addr", imem_addr, 64'h103);

        // Stall and bubble together: hold everything for two edges
        D_stall = 1'b1; D_bubble = 1'b1; F_stall = 1'b1;
        imem_data = I_NOP;
        step();
        step();
        check_val("hold_icode", {60'd0, D_icode}, 64'd0);
        check_val("hold_stat", {62'd0, D_stat}, 64'd1);
        check_val("hold_valp", D_valP, 64'h103);
        check_val("hold_addr", imem_addr, 64'h103);

        // Bubble alone
        D_stall = 1'b0; F_stall = 1'b0;
        step();
        check_val("bub_icode", {60'd0, D_icode}, 64'd1);
        check_val("bub_stat", {62'd0, D_stat}, 64'd0);
        check_val("bub_valp", D_valP, 64'd0);
        check_val("bub_addr", imem_addr, 64'h104);
        D_bubble = 1'b0;

        // Instruction memory fault at 0x104
        imem_err  = 1'b1;
        imem_data = I_IRMOVQ;
        step();
        check_val("adr_stat", {62'd0, D_stat}, 64'd2);
        check_val("adr_icode", {60'd0, D_icode}, 64'd1);
        check_val("adr_rb", {60'd0, D_rB}, 64'hF);
        check_val("adr_valc", D_valC, 64'd0);
        check_val("adr_valp", D_valP, 64'h104);
        imem_err = 1'b0;

        // Load a real instruction, then pulse reset between edges
        step();
        check_val("pre_rst_icode", {60'd0, D_icode}, 64'd3);
        #3;
        rst = 1'b1;
        #1;
        check_val("arst_icode", {60'd0, D_icode}, 64'd1);
        check_val("arst_valc", D_valC, 64'd0);
        check_val("arst_addr", imem_addr, 64'd0);
        #1;
        rst = 1'b0;
        step();
        check_val("resume_valp", D_valP, 64'd10);
        check_val("resume_addr", imem_addr, 64'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/y86_fetch_stage.md
Y86_FETCH_STAGE -- requirements
Module: y86_fetch_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 F_stall, D_stall, D_bubble  input  1 each  pipeline-control hold/hold/inject-nop.
REQ-004 M_icode  input  4 | M_Cnd  input  1 | M_valA  input  64  memory-stage branch-resolution data.
REQ-005 W_icode  input  4 | W_valM  input  64  write-back-stage return-address data.
REQ-006 imem_addr  output  64  fetch address (selected PC), combinational.
REQ-007 imem_data  input  80 | imem_err  input  1  ten instruction bytes returned for imem_addr in the same cycle; byte i = imem_data[8i+7:8i].
REQ-008 D_stat  output  2  D-register status: AOK=0, HLT=1, ADR=2, INS=3.
REQ-009 D_icode, D_ifun, D_rA, D_rB  output  4 each  D-register instruction fields.
REQ-010 D_valC, D_valP  output  64 each  D-register constant and next-sequential PC.

Function
REQ-011 Selected PC: M_icode==7 with M_Cnd==0 -> M_valA; else W_icode==9 -> W_valM; else F_predPC; first match wins.
REQ-012 icode = byte0[7:4], ifun = byte0[3:0]; rA = byte1[7:4], rB = byte1[3:0] when need_regids, else rA = rB = 4'hF.
REQ-013 need_regids = icode in {2,3,4,5,6,A,B}; need_valC = icode in {3,4,5,7,8}.
REQ-014 valC = little-endian bytes 2..9 when need_regids, bytes 1..8 otherwise; 0 when not need_valC.
REQ-015 valP = PC + 1 + need_regids + 8*need_valC, modulo 2^64.
REQ-016 instr_valid: icode<=B and ifun==0, except icode 2 or 7 (ifun<=6) and icode 6 (ifun<=3).
REQ-017 Fetched stat: imem_err -> ADR; else !instr_valid -> INS; else icode==0 -> HLT; else AOK.
REQ-018 On imem_err the D fields SHALL load icode=1 (nop), ifun=0, rA=rB=F, valC=0, valP=PC.
REQ-019 Predicted PC: valC for icode 7 or 8; valP otherwise; loaded into F_predPC each edge unless F_stall.
REQ-020 D register: D_stall -> hold; else D_bubble -> load bubble (stat AOK, icode 1, ifun 0, rA=rB=F, valC=valP=0); else load fetched values.
REQ-021 D_stall and D_bubble both high: D_stall SHALL win (hold).
REQ-022 F_stall alone SHALL hold F_predPC while D still loads per REQ-020.
REQ-023 Latency: one cycle from imem_data to D outputs; imem_addr is combinational from state and M/W inputs.

Reset
REQ-024 rst high SHALL immediately set F_predPC=0 and D register to the bubble value of REQ-020, overriding every control input.
REQ-025 Reset deasserted mid-stream SHALL resume fetch at PC 0 on the first subsequent edge.

Structure
REQ-026 Shared package y86_pkg SHALL hold icode constants (HALT..POPQ), stat encodings, register-none (4'hF) and bubble field values.
REQ-027 Combinational byte split/decoder SHALL be sub-module y86_fetch_align (imem_data, PC -> icode, ifun, rA, rB, valC, valP, need_regids, need_valC, instr_valid).
REQ-028 Only F_predPC and the D register are state; no other storage.

Verification
REQ-029 After reset, imem bytes 30 F0 10 00 00 00 00 00 00 00 -> next edge D_icode=3, D_rA=F, D_rB=0, D_valC=0x10, D_valP=10, D_stat=AOK, imem_addr then 10.
REQ-030 At PC 0x20, bytes 70 00 01 00 00 00 00 00 00 (jmp 0x100) -> D_valP=0x29, next imem_addr=0x100; later M_icode=7, M_Cnd=0, M_valA=0x29 -> imem_addr=0x29 in that cycle.
REQ-031 W_icode=9, W_valM=0x400 with M_icode=7, M_Cnd=0, M_valA=0x50 -> imem_addr=0x50; M_Cnd=1 -> imem_addr=0x400.
REQ-032 Byte0 0x65 -> D_stat=INS; byte0 0x00 -> D_stat=HLT; imem_err=1 -> D_stat=ADR, D_icode=1.
REQ-033 D_stall=1 and D_bubble=1 for 2 cycles with F_stall=1 -> D outputs and imem_addr unchanged; D_bubble alone -> D_icode=1, D_stat=AOK.
REQ-034 rst pulsed asynchronously between edges mid-program -> outputs bubble and imem_addr=0 before the next edge.
